// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: ctrl_state encoding,
// reset PC and register-index width.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [63:0] RESET_PC  = 64'h8000_0000;

    typedef enum logic [1:0] {
        CTRL_BOOT     = 2'd0,
        CTRL_RUN      = 2'd1,
        CTRL_MEM_WAIT = 2'd2,
        CTRL_MDU_WAIT = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator: flags an ID source that a load in EX is
// about to write. x0 never counts.
module pipe_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic                 ex_valid_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_is_load_i,
    output logic                 lu_hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match   = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_match   = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    assign lu_hazard_o = ex_valid_i && ex_is_load_i && (ex_rd_i != '0) &&
                         (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: drives stage-register enables and bubble
// inserts. Optional stall counters behind macro PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned PERF_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 if_ready_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic                 ex_valid_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_is_load_i,
    input  logic                 ex_redirect_i,
    input  logic                 ex_mdu_busy_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    output logic                 if_en_o,
    output logic                 id_en_o,
    output logic                 ex_en_o,
    output logic                 mem_en_o,
    output logic                 wb_en_o,
    output logic                 id_flush_o,
    output logic                 ex_flush_o,
    output logic                 mem_flush_o,
    output logic                 wb_flush_o,
    output logic [1:0]           ctrl_state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_mem_stall_o,
    output logic [PERF_W-1:0]    perf_mdu_stall_o,
    output logic [PERF_W-1:0]    perf_lu_stall_o,
    output logic [PERF_W-1:0]    perf_flush_o
`endif
);

    localparam int unsigned CntW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastBoot = CntW'(BOOT_CYCLES - 1);

    ctrl_state_e     state_q, state_d;
    logic [CntW-1:0] boot_cnt_q, boot_cnt_d;
    logic            lu_hazard;
    logic            fire_mem, fire_mdu, fire_redir, fire_lu;

    pipe_hazard_detect u_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_valid_i    (ex_valid_i),
        .ex_rd_i       (ex_rd_i),
        .ex_is_load_i  (ex_is_load_i),
        .lu_hazard_o   (lu_hazard)
    );

    always_comb begin
        if_en_o     = 1'b0;
        id_en_o     = 1'b0;
        ex_en_o     = 1'b0;
        mem_en_o    = 1'b0;
        wb_en_o     = 1'b0;
        id_flush_o  = 1'b1;
        ex_flush_o  = 1'b1;
        mem_flush_o = 1'b1;
        wb_flush_o  = 1'b1;
        fire_mem    = 1'b0;
        fire_mdu    = 1'b0;
        fire_redir  = 1'b0;
        fire_lu     = 1'b0;
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;

        if (state_q == CTRL_BOOT) begin
            boot_cnt_d = boot_cnt_q + CntW'(1);
            if (boot_cnt_q == LastBoot) begin
                state_d = CTRL_RUN;
            end
        end else begin
            if_en_o     = 1'b1;
            id_en_o     = 1'b1;
            ex_en_o     = 1'b1;
            mem_en_o    = 1'b1;
            wb_en_o     = 1'b1;
            id_flush_o  = 1'b0;
            ex_flush_o  = 1'b0;
            mem_flush_o = 1'b0;
            wb_flush_o  = 1'b0;
            state_d     = CTRL_RUN;

            // Stalls hold EX, so a coincident redirect simply re-presents later.
            if (mem_req_i && !mem_ready_i) begin
                fire_mem   = 1'b1;
                if_en_o    = 1'b0;
                id_en_o    = 1'b0;
                ex_en_o    = 1'b0;
                mem_en_o   = 1'b0;
                wb_flush_o = 1'b1;
                state_d    = CTRL_MEM_WAIT;
            end else if (ex_mdu_busy_i) begin
                fire_mdu    = 1'b1;
                if_en_o     = 1'b0;
                id_en_o     = 1'b0;
                ex_en_o     = 1'b0;
                mem_flush_o = 1'b1;
                state_d     = CTRL_MDU_WAIT;
            end else if (ex_redirect_i) begin
                fire_redir = 1'b1;
                id_flush_o = 1'b1;
                ex_flush_o = 1'b1;
            end else if (lu_hazard) begin
                fire_lu    = 1'b1;
                if_en_o    = 1'b0;
                id_en_o    = 1'b0;
                ex_flush_o = 1'b1;
            end else if (!if_ready_i) begin
                if_en_o    = 1'b0;
                id_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CTRL_BOOT;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    assign ctrl_state_o = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] mem_cnt_q, mdu_cnt_q, lu_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_cnt_q   <= '0;
            mdu_cnt_q   <= '0;
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fire_mem && (mem_cnt_q != '1))     mem_cnt_q   <= mem_cnt_q + 1'b1;
            if (fire_mdu && (mdu_cnt_q != '1))     mdu_cnt_q   <= mdu_cnt_q + 1'b1;
            if (fire_lu && (lu_cnt_q != '1))       lu_cnt_q    <= lu_cnt_q + 1'b1;
            if (fire_redir && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign perf_mem_stall_o = mem_cnt_q;
    assign perf_mdu_stall_o = mdu_cnt_q;
    assign perf_lu_stall_o  = lu_cnt_q;
    assign perf_flush_o     = flush_cnt_q;
`endif

endmodule
